serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised bit-serial adder, the sequential successor to the combinational full/half adder cells. It adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using a single full-adder stage and a carry flip-flop. A start/busy/done handshake lets a controller launch an addition and collect a registered result. Sits between operand registers and any datapath that trades area for latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an addition; sampled on rising clk
a  input  WIDTH  operand A; sampled only when start is accepted
b  input  WIDTH  operand B; sampled only when start is accepted
cin  input  1  carry-in; sampled only when start is accepted
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result is valid from this cycle onward
sum  output  WIDTH  registered sum, held until the next completion
cout  output  1  registered carry-out of the MSB
overflow  output  1  registered two's-complement overflow flag

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, whether asserted while idle or mid-operation, forces:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, overflow=0
  - internal shift registers, carry and bit counter cleared
  - any addition in progress is aborted with no result update
- States:
  - IDLE: start=1 is accepted. On that edge:
    - a and b are latched into shift registers.
    - cin is latched into the carry flip-flop.
    - The counter is set to 0 and the FSM moves to RUN.
  - RUN: busy=1. Each edge performs one full-adder step on shiftA[0], shiftB[0] and carry:
    - Both operand registers shift right.
    - The sum bit is shifted into the MSB of the result shift register.
    - carry is updated and the counter increments.
    - On the edge where the counter equals WIDTH-1, the FSM goes to DONE and the holding outputs load:
      - sum <= completed result
      - cout <= final carry
      - overflow <= carry into the MSB XOR carry out of the MSB
  - DONE: done=1 and busy=0 for exactly one cycle. The next state is IDLE, unless start=1 in this cycle; in that case the start is accepted exactly as in IDLE (back-to-back operation) and the next state is RUN.
- Latency: start is accepted at edge E0. done is high during the cycle following edge E0+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- start is ignored while in RUN. Operand inputs may change freely after acceptance.
- sum, cout and overflow change only on the completion edge (or on reset). They are stable throughout RUN and hold the previous result.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). overflow is meaningful when a and b are interpreted as signed values.
- The carry into the MSB is captured on the step where the counter equals WIDTH-1, before that step's carry update.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, start pulsed -> busy high for 8 cycles; done pulses 1 cycle; sum=0x10, cout=0, overflow=0.
- WIDTH=8, two separate additions:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
  - a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
- WIDTH=8, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1. Then, in the same test, start is held high through the DONE cycle with a=0x01, b=0x02 -> the second addition launches with no IDLE gap, and its done arrives 9 cycles after the first done with sum=0x03.
- WIDTH=8, start with a=0x11, b=0x22, then start pulsed again and operands changed to 0xFF/0xFF mid-RUN -> the second start is ignored and sum=0x33 at done. sum must stay at its previous value until the completion edge.
- Reset asserted asynchronously (between clock edges) at bit 4 of an addition -> busy, done, sum, cout and overflow are 0 immediately; no done pulse follows. A new start after reset release produces a correct result.
- WIDTH=4, exhaustive sweep over all a, b and cin (512 cases) -> every {cout,sum} equals a+b+cin. overflow is checked against a signed reference. done arrives exactly 4 cycles after each accepted start.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder: the controller (master) launches
// an addition, and the adder (slave) returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage plus a carry flip-flop, LSB first,
// with a start/busy/done handshake and result registers held between completions.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] res_next;
    logic             last_step;

    always_comb begin
        bit_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
        bit_carry = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));
        res_next  = {bit_sum, res_sh_reg[WIDTH-1:1]};
        last_step = (cnt_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                // DONE accepts a new start exactly like IDLE, giving back-to-back operation
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_sh_reg   <= bus.a;
                        b_sh_reg   <= bus.b;
                        carry_reg  <= bus.cin;
                        res_sh_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= res_next;
                    carry_reg  <= bit_carry;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_step) begin
                        // carry_reg still holds the carry into the MSB on this step
                        sum_reg   <= res_next;
                        cout_reg  <= bit_carry;
                        ovf_reg   <= carry_reg ^ bit_carry;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.sum      = sum_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake, timing and
// reset scenarios, and a 4-bit instance swept over every operand combination.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_adder_if #(.WIDTH(8)) i8();
    serial_adder_if #(.WIDTH(4)) i4();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] prev;
        int k;
        int busy_n;
        logic stable;
        @(negedge clk);
        i8.a = av; i8.b = bv; i8.cin = cv; i8.start = 1'b1;
        prev = i8.sum;
        @(negedge clk);
        i8.start = 1'b0;
        i8.a = ~av; i8.b = ~bv; i8.cin = ~cv;
        k = 1; busy_n = 0; stable = 1'b1;
        while (i8.done !== 1'b1 && k < 40) begin
            if (i8.busy === 1'b1) busy_n++;
            if (i8.sum !== prev) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k - 1, 8);
        check({tag, "_busy_cycles"}, busy_n, 8);
        check({tag, "_sum_held"}, {31'd0, stable}, 1);
        check({tag, "_sum"}, {24'd0, i8.sum}, {24'd0, es});
        check({tag, "_cout_ovf"}, {30'd0, i8.cout, i8.overflow}, {30'd0, ec, eo});
        $display("op8 %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d", tag, av, bv, cv,
                 i8.sum, i8.cout, i8.overflow);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, i8.done, i8.busy}, 0);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        int k;
        int sa;
        int sb;
        int ss;
        logic [4:0] tot;
        logic eo;
        @(negedge clk);
        i4.a = av; i4.b = bv; i4.cin = cv; i4.start = 1'b1;
        @(negedge clk);
        i4.start = 1'b0;
        k = 1;
        while (i4.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tot = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
        sa  = av[3] ? int'(av) - 16 : int'(av);
        sb  = bv[3] ? int'(bv) - 16 : int'(bv);
        ss  = sa + sb + int'(cv);
        eo  = (ss > 7) || (ss < -8);
        check("w4_result", {26'd0, i4.overflow, i4.cout, i4.sum}, {26'd0, eo, tot});
        check("w4_latency", k - 1, 4);
    endtask

    initial begin
        int k;
        logic saw_done;
        checks = 0; failures = 0;
        rst = 1'b1;
        i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
        i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0;
        #1;
        check("reset_outputs", {19'd0, i8.busy, i8.done, i8.sum, i8.cout, i8.overflow}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {19'd0, i8.busy, i8.done, i8.sum, i8.cout, i8.overflow}, 0);
        check("idle_w4", {25'd0, i4.busy, i4.done, i4.sum, i4.cout, i4.overflow}, 0);

        op8("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("pos_ovf", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // back-to-back: start stays high through RUN and the DONE cycle
        @(negedge clk);
        i8.a = 8'h80; i8.b = 8'h80; i8.cin = 1'b0; i8.start = 1'b1;
        @(negedge clk);
        k = 1;
        while (i8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_latency", k - 1, 8);
        check("b2b_first_result", {22'd0, i8.overflow, i8.cout, i8.sum}, {22'd0, 1'b1, 1'b1, 8'h00});
        $display("b2b first a=80 b=80 -> sum=%02h cout=%0d ovf=%0d", i8.sum, i8.cout, i8.overflow);
        i8.a = 8'h01; i8.b = 8'h02;
        @(negedge clk);
        i8.start = 1'b0;
        check("b2b_no_gap", {30'd0, i8.busy, i8.done}, 2);
        k = 1;
        while (i8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_gap", k, 9);
        check("b2b_second_result", {22'd0, i8.overflow, i8.cout, i8.sum}, {22'd0, 1'b0, 1'b0, 8'h03});
        $display("b2b second a=01 b=02 -> sum=%02h gap=%0d", i8.sum, k);

        // second start during RUN is ignored; operands scrambled after acceptance
        @(negedge clk);
        i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0; i8.start = 1'b1;
        @(negedge clk);
        i8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF;
        @(negedge clk);
        i8.start = 1'b0;
        check("ignore_sum_held", {24'd0, i8.sum}, 32'h03);
        k = 4;
        while (i8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ignore_latency", k - 1, 8);
        check("ignore_result", {22'd0, i8.overflow, i8.cout, i8.sum}, {22'd0, 1'b0, 1'b0, 8'h33});
        $display("ignore a=11 b=22 -> sum=%02h", i8.sum);
        @(negedge clk);
        check("ignore_no_relaunch", {30'd0, i8.busy, i8.done}, 0);

        // asynchronous reset between edges, mid-addition
        @(negedge clk);
        i8.a = 8'h55; i8.b = 8'h0F; i8.cin = 1'b0; i8.start = 1'b1;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {19'd0, i8.busy, i8.done, i8.sum, i8.cout, i8.overflow}, 0);
        $display("async reset mid-run -> busy=%0d done=%0d sum=%02h", i8.busy, i8.done, i8.sum);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i8.done !== 1'b0 || i8.busy !== 1'b0) saw_done = 1'b1;
        end
        check("no_activity_after_reset", {31'd0, saw_done}, 0);
        op8("post_reset", 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    op4(4'(ai), 4'(bi), 1'(ci));
                end
            end
        end
        $display("w4 sweep complete: 512 cases");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
